// File: rtl/ser2par.sv
// Serial-to-parallel converter: packs a 1-bit valid/ready stream into WIDTH-bit words.
// Words close early on din_last. A one-word hold slot absorbs a stalled output register.
module ser2par #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  input  logic                       din_vld,
  input  logic                       din_last,
  output logic                       dout_rdy,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(WIDTH+1)-1:0] dout_nbits,
  output logic                       dout_last,
  output logic                       dout_vld,
  input  logic                       din_rdy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NW = $clog2(WIDTH + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [NW-1:0]    hold_nbits;
  logic             hold_last;

  logic             accept;
  logic             complete;
  logic             out_free;
  logic             load;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] merged;
  logic [NW-1:0]    fill_nbits;
  logic [WIDTH-1:0] load_word;
  logic [NW-1:0]    load_nbits;
  logic             load_last;

  // Ready depends only on the FSM state; masking with rst keeps it low during reset.
  assign dout_rdy = (state == ACCUM) && !rst;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    accept      = din_vld && (state == ACCUM);
    pos         = LSB_FIRST ? cnt : CW'(WIDTH - 1) - cnt;
    merged      = acc;
    merged[pos] = din;
    complete    = accept && ((cnt == CW'(WIDTH - 1)) || din_last);
    out_free    = !dout_vld || din_rdy;
    fill_nbits  = NW'(cnt) + NW'(1);

    load        = 1'b0;
    load_word   = merged;
    load_nbits  = fill_nbits;
    load_last   = din_last;
    if (state == HOLD) begin
      load       = out_free;
      load_word  = acc;
      load_nbits = hold_nbits;
      load_last  = hold_last;
    end else begin
      load = complete && out_free;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCUM;
      acc        <= '0;
      cnt        <= '0;
      hold_nbits <= '0;
      hold_last  <= 1'b0;
      dout       <= '0;
      dout_nbits <= '0;
      dout_last  <= 1'b0;
      dout_vld   <= 1'b0;
    end else begin
      // A load in the same cycle as a delivery replaces the word and keeps valid high.
      if (load) begin
        dout       <= load_word;
        dout_nbits <= load_nbits;
        dout_last  <= load_last;
        dout_vld   <= 1'b1;
      end else if (din_rdy) begin
        dout_vld <= 1'b0;
      end

      case (state)
        ACCUM: begin
          if (accept) begin
            if (!complete) begin
              acc <= merged;
              cnt <= cnt + CW'(1);
            end else if (out_free) begin
              acc <= '0;
              cnt <= '0;
            end else begin
              // Output register busy: park the finished word in acc.
              acc        <= merged;
              hold_nbits <= fill_nbits;
              hold_last  <= din_last;
              state      <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_free) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule
